// File: rtl/id_stage_pkg.sv
// Shared decode constants and types for the RV32I integer decode stage.
package id_stage_pkg;

  localparam int ALU_OP_W  = 8;
  localparam int ALU_SEL_W = 3;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [ALU_OP_W-1:0] EXE_NOP_OP  = 8'h00;
  localparam logic [ALU_OP_W-1:0] EXE_AND_OP  = 8'h24;
  localparam logic [ALU_OP_W-1:0] EXE_OR_OP   = 8'h25;
  localparam logic [ALU_OP_W-1:0] EXE_XOR_OP  = 8'h26;
  localparam logic [ALU_OP_W-1:0] EXE_SLL_OP  = 8'h7c;
  localparam logic [ALU_OP_W-1:0] EXE_SRL_OP  = 8'h02;
  localparam logic [ALU_OP_W-1:0] EXE_SRA_OP  = 8'h03;
  localparam logic [ALU_OP_W-1:0] EXE_ADD_OP  = 8'h20;
  localparam logic [ALU_OP_W-1:0] EXE_SUB_OP  = 8'h22;
  localparam logic [ALU_OP_W-1:0] EXE_SLT_OP  = 8'h2a;
  localparam logic [ALU_OP_W-1:0] EXE_SLTU_OP = 8'h2b;

  localparam logic [ALU_SEL_W-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [ALU_SEL_W-1:0] EXE_RES_ARITH = 3'b100;

  typedef enum logic [1:0] {
    OPA_ZERO = 2'd0,
    OPA_RS1  = 2'd1,
    OPA_PC   = 2'd2
  } opa_e;

  typedef enum logic [2:0] {
    OPB_ZERO  = 3'd0,
    OPB_RS2   = 3'd1,
    OPB_IMM   = 3'd2,
    OPB_SHAMT = 3'd3,
    OPB_UIMM  = 3'd4
  } opb_e;

  typedef struct packed {
    logic [ALU_OP_W-1:0]  aluop;
    logic [ALU_SEL_W-1:0] alusel;
    logic                 use1;
    logic                 use2;
    logic                 wreg;
    logic                 illegal;
    opa_e                 opa;
    opb_e                 opb;
  } dec_t;

endpackage

// File: rtl/id_fwd_mux.sv
// Operand source select: x0 -> 0, else lowest-index matching bypass, else regfile.
module id_fwd_mux #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic [4:0]              rs,
  input  logic [XLEN-1:0]         reg_data,
  input  logic [NUM_FWD-1:0]      fwd_wreg,
  input  logic [5*NUM_FWD-1:0]    fwd_wd,
  input  logic [XLEN*NUM_FWD-1:0] fwd_wdata,
  output logic [XLEN-1:0]         data
);

  logic [XLEN-1:0] sel_s;

  // Scan oldest to youngest so the lowest matching index is applied last and wins.
  always_comb begin
    sel_s = reg_data;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      sel_s = (fwd_wreg[i] && (fwd_wd[5*i +: 5] == rs)) ? fwd_wdata[XLEN*i +: XLEN] : sel_s;
    end
    data = (rs == 5'd0) ? '0 : sel_s;
  end

endmodule

// File: rtl/id_stage.sv
// RV32I integer decode stage: decode, operand bypass, load-use interlock and ID/EX register
// with valid/ready handshake on both sides.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_FWD   = 2,
  parameter int HAZ_CHECK = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [XLEN-1:0]         pc_i,
  input  logic [31:0]             inst_i,
  output logic [4:0]              reg1_addr_o,
  output logic [4:0]              reg2_addr_o,
  input  logic [XLEN-1:0]         reg1_data_i,
  input  logic [XLEN-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]      fwd_wreg_i,
  input  logic [5*NUM_FWD-1:0]    fwd_wd_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_wdata_i,
  input  logic                    ld_pend_i,
  input  logic [4:0]              ld_wd_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [ALU_OP_W-1:0]     aluop_o,
  output logic [ALU_SEL_W-1:0]    alusel_o,
  output logic [XLEN-1:0]         reg1_o,
  output logic [XLEN-1:0]         reg2_o,
  output logic [4:0]              wd_o,
  output logic                    wreg_o,
  output logic [XLEN-1:0]         pc_o,
  output logic                    illegal_o
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic [4:0] rs1_s;
  logic [4:0] rs2_s;
  logic signed [11:0] imm_i_s;
  logic signed [31:0] imm_u_s;
  dec_t dec_s;
  logic [XLEN-1:0] fwd1_s, fwd2_s, op1_s, op2_s;
  logic hazard_s, accept_s;

  assign opcode_s    = inst_i[6:0];
  assign funct3_s    = inst_i[14:12];
  assign funct7_s    = inst_i[31:25];
  assign rs1_s       = inst_i[19:15];
  assign rs2_s       = inst_i[24:20];
  assign imm_i_s     = inst_i[31:20];
  assign imm_u_s     = {inst_i[31:12], 12'b0};
  assign reg1_addr_o = rs1_s;
  assign reg2_addr_o = rs2_s;

  // Instruction decode; anything not explicitly legal falls through as an illegal NOP.
  always_comb begin
    dec_s = '{aluop: EXE_NOP_OP, alusel: EXE_RES_NOP, use1: 1'b0, use2: 1'b0,
              wreg: 1'b0, illegal: 1'b1, opa: OPA_ZERO, opb: OPB_ZERO};
    case (opcode_s)
      OPC_OP_IMM: begin
        dec_s = '{aluop: EXE_ADD_OP, alusel: EXE_RES_ARITH, use1: 1'b1, use2: 1'b0,
                  wreg: 1'b1, illegal: 1'b0, opa: OPA_RS1, opb: OPB_IMM};
        case (funct3_s)
          F3_ADD:  dec_s.aluop = EXE_ADD_OP;
          F3_SLT:  dec_s.aluop = EXE_SLT_OP;
          F3_SLTU: dec_s.aluop = EXE_SLTU_OP;
          F3_XOR:  begin dec_s.aluop = EXE_XOR_OP; dec_s.alusel = EXE_RES_LOGIC; end
          F3_OR:   begin dec_s.aluop = EXE_OR_OP;  dec_s.alusel = EXE_RES_LOGIC; end
          F3_AND:  begin dec_s.aluop = EXE_AND_OP; dec_s.alusel = EXE_RES_LOGIC; end
          F3_SLL: begin
            dec_s.alusel = EXE_RES_SHIFT;
            dec_s.opb    = OPB_SHAMT;
            dec_s.aluop  = EXE_SLL_OP;
            dec_s.illegal = (funct7_s != F7_ZERO);
          end
          default: begin
            dec_s.alusel  = EXE_RES_SHIFT;
            dec_s.opb     = OPB_SHAMT;
            dec_s.aluop   = (funct7_s == F7_ALT) ? EXE_SRA_OP : EXE_SRL_OP;
            dec_s.illegal = (funct7_s != F7_ZERO) && (funct7_s != F7_ALT);
          end
        endcase
      end
      OPC_OP: begin
        dec_s = '{aluop: EXE_ADD_OP, alusel: EXE_RES_ARITH, use1: 1'b1, use2: 1'b1,
                  wreg: 1'b1, illegal: 1'b0, opa: OPA_RS1, opb: OPB_RS2};
        case (funct3_s)
          F3_ADD:  dec_s.aluop = (funct7_s == F7_ALT) ? EXE_SUB_OP : EXE_ADD_OP;
          F3_SLT:  dec_s.aluop = EXE_SLT_OP;
          F3_SLTU: dec_s.aluop = EXE_SLTU_OP;
          F3_XOR:  begin dec_s.aluop = EXE_XOR_OP; dec_s.alusel = EXE_RES_LOGIC; end
          F3_OR:   begin dec_s.aluop = EXE_OR_OP;  dec_s.alusel = EXE_RES_LOGIC; end
          F3_AND:  begin dec_s.aluop = EXE_AND_OP; dec_s.alusel = EXE_RES_LOGIC; end
          F3_SLL:  begin dec_s.aluop = EXE_SLL_OP; dec_s.alusel = EXE_RES_SHIFT; end
          default: begin
            dec_s.aluop  = (funct7_s == F7_ALT) ? EXE_SRA_OP : EXE_SRL_OP;
            dec_s.alusel = EXE_RES_SHIFT;
          end
        endcase
        // Only SUB and SRA may use the alternate funct7.
        dec_s.illegal = !((funct7_s == F7_ZERO) ||
                          ((funct7_s == F7_ALT) && ((funct3_s == F3_ADD) || (funct3_s == F3_SR))));
      end
      OPC_LUI: begin
        dec_s = '{aluop: EXE_OR_OP, alusel: EXE_RES_LOGIC, use1: 1'b0, use2: 1'b0,
                  wreg: 1'b1, illegal: 1'b0, opa: OPA_ZERO, opb: OPB_UIMM};
      end
      OPC_AUIPC: begin
        dec_s = '{aluop: EXE_ADD_OP, alusel: EXE_RES_ARITH, use1: 1'b0, use2: 1'b0,
                  wreg: 1'b1, illegal: 1'b0, opa: OPA_PC, opb: OPB_UIMM};
      end
      default: begin
        dec_s.illegal = 1'b1;
      end
    endcase
    if (dec_s.illegal) begin
      dec_s = '{aluop: EXE_NOP_OP, alusel: EXE_RES_NOP, use1: 1'b0, use2: 1'b0,
                wreg: 1'b0, illegal: 1'b1, opa: OPA_ZERO, opb: OPB_ZERO};
    end else begin
      dec_s.illegal = 1'b0;
    end
  end

  id_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd1 (
    .rs(rs1_s), .reg_data(reg1_data_i), .fwd_wreg(fwd_wreg_i),
    .fwd_wd(fwd_wd_i), .fwd_wdata(fwd_wdata_i), .data(fwd1_s)
  );

  id_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd2 (
    .rs(rs2_s), .reg_data(reg2_data_i), .fwd_wreg(fwd_wreg_i),
    .fwd_wd(fwd_wd_i), .fwd_wdata(fwd_wdata_i), .data(fwd2_s)
  );

  // Operand steering from the decoded source selects.
  always_comb begin
    case (dec_s.opa)
      OPA_RS1: op1_s = fwd1_s;
      OPA_PC:  op1_s = pc_i;
      default: op1_s = '0;
    endcase
    case (dec_s.opb)
      OPB_RS2:   op2_s = fwd2_s;
      OPB_IMM:   op2_s = XLEN'(imm_i_s);
      OPB_SHAMT: op2_s = XLEN'(rs2_s);
      OPB_UIMM:  op2_s = XLEN'(imm_u_s);
      default:   op2_s = '0;
    endcase
  end

  assign hazard_s = (HAZ_CHECK != 0) && ld_pend_i && (ld_wd_i != 5'd0) &&
                    ((dec_s.use1 && (rs1_s == ld_wd_i)) || (dec_s.use2 && (rs2_s == ld_wd_i)));
  assign in_ready_o = (!out_valid_o || out_ready_i) && !hazard_s && !flush_i;
  assign accept_s   = in_valid_i && in_ready_o;

  // ID/EX register: flush beats accept, accept beats drain, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_o <= 1'b0;
      aluop_o     <= EXE_NOP_OP;
      alusel_o    <= EXE_RES_NOP;
      reg1_o      <= '0;
      reg2_o      <= '0;
      wd_o        <= 5'd0;
      wreg_o      <= 1'b0;
      pc_o        <= '0;
      illegal_o   <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (accept_s) begin
      out_valid_o <= 1'b1;
      aluop_o     <= dec_s.aluop;
      alusel_o    <= dec_s.alusel;
      reg1_o      <= op1_s;
      reg2_o      <= op2_s;
      wd_o        <= inst_i[11:7];
      wreg_o      <= dec_s.wreg;
      pc_o        <= pc_i;
      illegal_o   <= dec_s.illegal;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end else begin
      out_valid_o <= out_valid_o;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed, table-driven bench for id_stage plus hand sequences for stall, interlock, flush, reset.
module tb_id_stage;
  import id_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i, in_valid_i, in_ready_o;
  logic [31:0] pc_i, inst_i;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic [1:0]  fwd_wreg_i;
  logic [9:0]  fwd_wd_i;
  logic [63:0] fwd_wdata_i;
  logic        ld_pend_i;
  logic [4:0]  ld_wd_i;
  logic        out_valid_o, out_ready_i;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [31:0] reg1_o, reg2_o, pc_o;
  logic [4:0]  wd_o;
  logic        wreg_o, illegal_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32), .NUM_FWD(2), .HAZ_CHECK(1)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .inst_i(inst_i), .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i), .fwd_wreg_i(fwd_wreg_i),
    .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i), .ld_pend_i(ld_pend_i), .ld_wd_i(ld_wd_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o),
    .illegal_o(illegal_o)
  );

  typedef struct {
    logic [31:0] inst, pc, rd1, rd2;
    logic [1:0]  fwreg;
    logic [9:0]  fwd;
    logic [63:0] fwdata;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] r1, r2;
    logic [4:0]  wd;
    logic        wreg, ill;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] rd1, input logic [31:0] rd2);
    inst_i = inst; pc_i = pc; reg1_data_i = rd1; reg2_data_i = rd2;
    fwd_wreg_i = 2'b00; fwd_wd_i = 10'd0; fwd_wdata_i = 64'd0;
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 32'h00000100, 32'h00001234, 32'h0, 2'b01, {5'd0, 5'd0},
                 {32'h0, 32'h0000DEAD}, EXE_ADD_OP, EXE_RES_ARITH, 32'h0, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0};
    vecs[1]  = '{32'h002081B3, 32'h00000104, 32'h00000011, 32'h9, 2'b11, {5'd1, 5'd1},
                 {32'd7, 32'd5}, EXE_ADD_OP, EXE_RES_ARITH, 32'd5, 32'd9, 5'd3, 1'b1, 1'b0};
    vecs[2]  = '{32'h40208233, 32'h00000108, 32'h00000011, 32'h22, 2'b10, {5'd1, 5'd2},
                 {32'h77, 32'hAA}, EXE_SUB_OP, EXE_RES_ARITH, 32'h77, 32'h22, 5'd4, 1'b1, 1'b0};
    vecs[3]  = '{32'h00533293, 32'h0000010C, 32'h00000100, 32'h0, 2'b01, {5'd0, 5'd6},
                 {32'h0, 32'h200}, EXE_SLTU_OP, EXE_RES_ARITH, 32'h200, 32'd5, 5'd5, 1'b1, 1'b0};
    vecs[4]  = '{32'h8000C393, 32'h00000110, 32'h00000F0F, 32'h0, 2'b00, 10'd0,
                 64'd0, EXE_XOR_OP, EXE_RES_LOGIC, 32'h0F0F, 32'hFFFFF800, 5'd7, 1'b1, 1'b0};
    vecs[5]  = '{32'h4030D093, 32'h00000114, 32'h80000000, 32'h0, 2'b00, 10'd0,
                 64'd0, EXE_SRA_OP, EXE_RES_SHIFT, 32'h80000000, 32'd3, 5'd1, 1'b1, 1'b0};
    vecs[6]  = '{32'h0210D093, 32'h00000118, 32'h5, 32'h5, 2'b00, 10'd0,
                 64'd0, EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1};
    vecs[7]  = '{32'h123452B7, 32'h0000011C, 32'hAAAA, 32'hBBBB, 2'b11, {5'd8, 5'd8},
                 {32'h1, 32'h2}, EXE_OR_OP, EXE_RES_LOGIC, 32'h0, 32'h12345000, 5'd5, 1'b1, 1'b0};
    vecs[8]  = '{32'hFFFFF317, 32'h80000010, 32'h1, 32'h2, 2'b00, 10'd0,
                 64'd0, EXE_ADD_OP, EXE_RES_ARITH, 32'h80000010, 32'hFFFFF000, 5'd6, 1'b1, 1'b0};
    vecs[9]  = '{32'h00A49433, 32'h00000120, 32'h1, 32'h4, 2'b00, 10'd0,
                 64'd0, EXE_SLL_OP, EXE_RES_SHIFT, 32'h1, 32'h4, 5'd8, 1'b1, 1'b0};
    vecs[10] = '{32'h4020E1B3, 32'h00000124, 32'h1, 32'h2, 2'b00, 10'd0,
                 64'd0, EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd3, 1'b0, 1'b1};
    vecs[11] = '{32'h00000073, 32'h00000128, 32'h1, 32'h2, 2'b00, 10'd0,
                 64'd0, EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1};

    rst = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    ld_pend_i = 1'b0; ld_wd_i = 5'd0;
    drive(32'h0, 32'h0, 32'h0, 32'h0);
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    chk("rst_valid", {63'd0, out_valid_o}, 64'd0);
    chk("rst_aluop", {56'd0, aluop_o}, {56'd0, EXE_NOP_OP});
    chk("rst_alusel", {61'd0, alusel_o}, {61'd0, EXE_RES_NOP});
    chk("rst_reg2_wd_wreg", {26'd0, reg2_o, wd_o, wreg_o}, 64'd0);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].inst, vecs[i].pc, vecs[i].rd1, vecs[i].rd2);
      fwd_wreg_i = vecs[i].fwreg; fwd_wd_i = vecs[i].fwd; fwd_wdata_i = vecs[i].fwdata;
      in_valid_i = 1'b1;
      #1;
      chk($sformatf("v%0d_in_ready", i), {63'd0, in_ready_o}, 64'd1);
      cyc();
      chk($sformatf("v%0d_valid", i), {63'd0, out_valid_o}, 64'd1);
      chk($sformatf("v%0d_aluop_sel", i), {53'd0, aluop_o, alusel_o}, {53'd0, vecs[i].aluop, vecs[i].alusel});
      chk($sformatf("v%0d_reg1", i), {32'd0, reg1_o}, {32'd0, vecs[i].r1});
      chk($sformatf("v%0d_reg2", i), {32'd0, reg2_o}, {32'd0, vecs[i].r2});
      chk($sformatf("v%0d_wd_wreg_ill", i), {57'd0, wd_o, wreg_o, illegal_o},
          {57'd0, vecs[i].wd, vecs[i].wreg, vecs[i].ill});
      chk($sformatf("v%0d_pc", i), {32'd0, pc_o}, {32'd0, vecs[i].pc});
    end

    // Load-use interlock: ADD x3,x1,x2 behind a load to x1.
    drive(32'h002081B3, 32'h200, 32'h1, 32'h2);
    ld_pend_i = 1'b1; ld_wd_i = 5'd1;
    #1 chk("haz_ready_low", {63'd0, in_ready_o}, 64'd0);
    cyc();
    chk("haz_bubble", {63'd0, out_valid_o}, 64'd0);
    ld_pend_i = 1'b0;
    #1 chk("haz_ready_high", {63'd0, in_ready_o}, 64'd1);
    cyc();
    chk("haz_accept", {58'd0, out_valid_o, wd_o}, {58'd0, 1'b1, 5'd3});
    chk("haz_reg1", {32'd0, reg1_o}, 64'd1);

    // Downstream stall for three cycles with a new op offered.
    out_ready_i = 1'b0;
    drive(32'h123452B7, 32'h204, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("stall%0d_ready", k), {63'd0, in_ready_o}, 64'd0);
      cyc();
      chk($sformatf("stall%0d_hold", k), {26'd0, out_valid_o, wd_o, reg1_o},
          {26'd0, 1'b1, 5'd3, 32'h1});
      chk($sformatf("stall%0d_pc", k), {32'd0, pc_o}, 64'h200);
    end
    out_ready_i = 1'b1;
    #1 chk("stall_release_ready", {63'd0, in_ready_o}, 64'd1);
    cyc();
    chk("stall_next_op", {26'd0, out_valid_o, wd_o, reg2_o}, {26'd0, 1'b1, 5'd5, 32'h12345000});

    // Flush with valid ID/EX and a valid offered op.
    out_ready_i = 1'b0;
    drive(32'hFFF00093, 32'h208, 32'h0, 32'h0);
    flush_i = 1'b1;
    #1 chk("flush_ready", {63'd0, in_ready_o}, 64'd0);
    cyc();
    chk("flush_valid", {63'd0, out_valid_o}, 64'd0);
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    cyc();
    chk("flush_not_taken", {58'd0, out_valid_o, wd_o}, {58'd0, 1'b0, 5'd5});

    // Reset asserted while stalled.
    in_valid_i = 1'b1;
    cyc();
    chk("prerst_load", {58'd0, out_valid_o, wd_o}, {58'd0, 1'b1, 5'd1});
    out_ready_i = 1'b0;
    drive(32'hFFFFF317, 32'h20C, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    chk("midrst_clear", {18'd0, out_valid_o, aluop_o, reg2_o, wd_o}, {18'd0, 1'b0, EXE_NOP_OP, 32'h0, 5'd0});
    cyc();
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    rst = 1'b1;
    cyc();
    chk("postrst_idle", {63'd0, out_valid_o}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
